// File: rtl/montgomery_reduce_stream.sv
// Streaming Montgomery reducer: result = x * R^-1 mod q, R = 2^k.
// Fixed-latency pipeline with valid/ready back-pressure and guarded config.
module montgomery_reduce_stream #(
  parameter int DATA_W  = 64,
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        cfg_load_i,
  input  logic [DATA_W-1:0]           cfg_q_i,
  input  logic [DATA_W-1:0]           cfg_qinv_i,
  input  logic [$clog2(DATA_W+1)-1:0] cfg_k_i,
  output logic                        cfg_err_o,
  output logic                        busy_o,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [2*DATA_W-1:0]         x_i,
  input  logic [TAG_W-1:0]            tag_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_W-1:0]           result_o,
  output logic [TAG_W-1:0]            tag_o
);
  localparam int KW = $clog2(DATA_W+1);
  localparam int XW = 2*DATA_W;
  localparam int ML = MUL_LAT;

  logic [DATA_W-1:0] q_r;
  logic [DATA_W-1:0] qinv_r;
  logic [KW-1:0]     k_r;

  logic              adv;
  logic              cfg_ok;
  logic [DATA_W:0]   pow_k;
  logic [DATA_W-1:0] mask;

  logic              s0_v;
  logic [XW-1:0]     s0_x;
  logic [TAG_W-1:0]  s0_tag;

  logic              s1_v;
  logic [XW-1:0]     s1_x;
  logic [TAG_W-1:0]  s1_tag;
  logic [DATA_W-1:0] s1_a;

  logic [ML-1:0]              m1_v;
  logic [ML-1:0][XW-1:0]      m1_x;
  logic [ML-1:0][TAG_W-1:0]   m1_tag;
  logic [ML-1:0][DATA_W-1:0]  m1_p;

  logic              sm_v;
  logic [XW-1:0]     sm_x;
  logic [TAG_W-1:0]  sm_tag;
  logic [DATA_W-1:0] sm_m;

  logic [ML-1:0]              m2_v;
  logic [ML-1:0][XW-1:0]      m2_x;
  logic [ML-1:0][TAG_W-1:0]   m2_tag;
  logic [ML-1:0][XW-1:0]      m2_p;

  logic              sa_v;
  logic [TAG_W-1:0]  sa_tag;
  logic [DATA_W:0]   sa_t;

  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] p1_nxt;
  logic [DATA_W-1:0] m_nxt;
  logic [XW-1:0]     p2_nxt;
  logic [XW:0]       sum;
  logic [XW:0]       sum_sh;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] red;
  logic              unused_bits;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv && !cfg_load_i;
  assign busy_o     = s0_v | s1_v | (|m1_v) | sm_v
                    | (|m2_v) | sa_v | out_valid_o;
  assign cfg_ok     = !busy_o && (cfg_k_i != '0)
                    && (cfg_k_i <= KW'(DATA_W));

  // k == DATA_W wraps pow_k's low bits to zero, giving an all-ones mask
  assign pow_k = (DATA_W+1)'(1) << k_r;
  assign mask  = pow_k[DATA_W-1:0] - DATA_W'(1);

  assign a_nxt  = s0_x[DATA_W-1:0] & mask;
  assign p1_nxt = s1_a * qinv_r;
  assign m_nxt  = m1_p[ML-1] & mask;
  assign p2_nxt = XW'(sm_m) * XW'(q_r);
  assign sum    = (XW+1)'(m2_x[ML-1]) + (XW+1)'(m2_p[ML-1]);
  assign sum_sh = sum >> k_r;
  assign diff   = sa_t - {1'b0, q_r};
  assign red    = (sa_t >= {1'b0, q_r}) ? diff[DATA_W-1:0]
                                        : sa_t[DATA_W-1:0];

  assign unused_bits = ^{sum_sh[XW:DATA_W+1], pow_k[DATA_W], diff[DATA_W]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_r       <= '0;
      qinv_r    <= '0;
      k_r       <= KW'(DATA_W);
      cfg_err_o <= 1'b0;
    end else begin
      cfg_err_o <= cfg_load_i && !cfg_ok;
      if (cfg_load_i && cfg_ok) begin
        q_r    <= cfg_q_i;
        qinv_r <= cfg_qinv_i;
        k_r    <= cfg_k_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_v   <= 1'b0;
      s0_x   <= '0;
      s0_tag <= '0;
      s1_v   <= 1'b0;
      s1_x   <= '0;
      s1_tag <= '0;
      s1_a   <= '0;
    end else if (adv) begin
      s0_v   <= in_valid_i && in_ready_o;
      s0_x   <= x_i;
      s0_tag <= tag_i;
      s1_v   <= s0_v;
      s1_x   <= s0_x;
      s1_tag <= s0_tag;
      s1_a   <= a_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m1_v   <= '0;
      m1_x   <= '0;
      m1_tag <= '0;
      m1_p   <= '0;
      sm_v   <= 1'b0;
      sm_x   <= '0;
      sm_tag <= '0;
      sm_m   <= '0;
    end else if (adv) begin
      m1_v[0]   <= s1_v;
      m1_x[0]   <= s1_x;
      m1_tag[0] <= s1_tag;
      m1_p[0]   <= p1_nxt;
      for (int i = 1; i < ML; i++) begin
        m1_v[i]   <= m1_v[i-1];
        m1_x[i]   <= m1_x[i-1];
        m1_tag[i] <= m1_tag[i-1];
        m1_p[i]   <= m1_p[i-1];
      end
      sm_v   <= m1_v[ML-1];
      sm_x   <= m1_x[ML-1];
      sm_tag <= m1_tag[ML-1];
      sm_m   <= m_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m2_v   <= '0;
      m2_x   <= '0;
      m2_tag <= '0;
      m2_p   <= '0;
      sa_v   <= 1'b0;
      sa_tag <= '0;
      sa_t   <= '0;
    end else if (adv) begin
      m2_v[0]   <= sm_v;
      m2_x[0]   <= sm_x;
      m2_tag[0] <= sm_tag;
      m2_p[0]   <= p2_nxt;
      for (int i = 1; i < ML; i++) begin
        m2_v[i]   <= m2_v[i-1];
        m2_x[i]   <= m2_x[i-1];
        m2_tag[i] <= m2_tag[i-1];
        m2_p[i]   <= m2_p[i-1];
      end
      sa_v   <= m2_v[ML-1];
      sa_tag <= m2_tag[ML-1];
      sa_t   <= sum_sh[DATA_W:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      tag_o       <= '0;
    end else if (adv) begin
      out_valid_o <= sa_v;
      result_o    <= red;
      tag_o       <= sa_tag;
    end
  end

endmodule
